// File: rtl/aib_link_seq_pkg.sv
// Shared types for the AIB link sequencer: state encoding and retry counter width.
package aib_link_seq_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DET = 3'd1,
        ST_CONFIG   = 3'd2,
        ST_LOCK_REQ = 3'd3,
        ST_LINK_UP  = 3'd4,
        ST_RETRY    = 3'd5,
        ST_FAIL     = 3'd6
    } state_e;

endpackage

// File: rtl/aib_link_tmr.sv
// Per-state timeout counter: cleared on state entry, saturates and flags after TMO_CYC ticked cycles.
// expired is high during the TMO_CYC-th ticked cycle since the last clear.
module aib_link_tmr #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aib_link_seq.sv
// AIB link bring-up sequencer: detect -> config -> DCC/DLL lock -> link up, with bounded retries.
// All outputs are registered from next-state so they change together with state_o.
module aib_link_seq
    import aib_link_seq_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CFG_CYC   = 8,
    parameter int TMO_CYC   = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic               osc_clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [NCH-1:0]     chan_en,
    input  logic               device_detect,
    input  logic               por,
    input  logic [NCH-1:0]     fs_mac_rdy,
    input  logic [NCH-1:0]     tx_transfer_en,
    input  logic [NCH-1:0]     rx_transfer_en,
    output logic [NCH-1:0]     config_done,
    output logic [NCH-1:0]     tx_dcc_dll_lock_req,
    output logic [NCH-1:0]     rx_dcc_dll_lock_req,
    output logic               link_up,
    output logic               link_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    localparam int CFG_W = (CFG_CYC > 1) ? $clog2(CFG_CYC + 1) : 1;

    state_e             state_q, state_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CFG_W-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic [NCH-1:0]     cfg_q, cfg_d, txreq_q, rxreq_q, req_d;
    logic               link_up_q, link_fail_q;
    logic               tmr_clr, tmr_tick, tmr_exp;
    logic               det_ok, xfer_ok, link_ok;

    // Unmasked channels are forced to "good" so they never gate progress.
    assign det_ok  = device_detect && !por && (&(fs_mac_rdy | ~mask_q));
    assign xfer_ok = &((tx_transfer_en & rx_transfer_en) | ~mask_q);
    assign link_ok = xfer_ok && (&(fs_mac_rdy | ~mask_q));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        retry_d = retry_q;
        if (!start) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mask_d  = chan_en;
                    state_d = (chan_en == '0) ? ST_FAIL : ST_WAIT_DET;
                end
                ST_WAIT_DET: begin
                    if (det_ok)       state_d = ST_CONFIG;
                    else if (tmr_exp) state_d = ST_FAIL;
                end
                ST_CONFIG: begin
                    if (cfg_cnt_q == CFG_W'(CFG_CYC - 1)) state_d = ST_LOCK_REQ;
                end
                ST_LOCK_REQ: begin
                    if (xfer_ok) begin
                        state_d = ST_LINK_UP;
                    end else if (tmr_exp) begin
                        state_d = ST_RETRY;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
                ST_LINK_UP: begin
                    if (!link_ok) begin
                        state_d = ST_RETRY;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
                ST_RETRY: begin
                    state_d = (retry_q == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_CONFIG;
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_cnt_d = '0;
        if (state_q == ST_CONFIG && state_d == ST_CONFIG) begin
            cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
        end
    end

    assign tmr_clr  = (state_d != state_q);
    assign tmr_tick = (state_q == ST_WAIT_DET) || (state_q == ST_LOCK_REQ);

    aib_link_tmr #(
        .TMO_CYC (TMO_CYC)
    ) u_tmr (
        .clk     (osc_clk),
        .rst_n   (rstn),
        .clr     (tmr_clr),
        .tick    (tmr_tick),
        .expired (tmr_exp)
    );

    // Outputs derive from next state so they are valid on the first cycle of a state.
    always_comb begin
        cfg_d = '0;
        req_d = '0;
        if (state_d == ST_CONFIG || state_d == ST_LOCK_REQ || state_d == ST_LINK_UP) begin
            cfg_d = mask_d;
        end
        if (state_d == ST_LOCK_REQ || state_d == ST_LINK_UP) begin
            req_d = mask_d;
        end
    end

    always_ff @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            retry_q     <= '0;
            cfg_cnt_q   <= '0;
            cfg_q       <= '0;
            txreq_q     <= '0;
            rxreq_q     <= '0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            retry_q     <= retry_d;
            cfg_cnt_q   <= cfg_cnt_d;
            cfg_q       <= cfg_d;
            txreq_q     <= req_d;
            rxreq_q     <= req_d;
            link_up_q   <= (state_d == ST_LINK_UP);
            link_fail_q <= (state_d == ST_FAIL);
        end
    end

    assign config_done         = cfg_q;
    assign tx_dcc_dll_lock_req = txreq_q;
    assign rx_dcc_dll_lock_req = rxreq_q;
    assign link_up             = link_up_q;
    assign link_fail           = link_fail_q;
    assign retry_cnt           = retry_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_aib_link_seq.sv
// Bench for aib_link_seq: directed bring-up/retry/abort/reset scenarios plus random traffic,
// all checked each cycle against a cycle-count reference model.
module tb_aib_link_seq;

    localparam int NCH  = 4;
    localparam int CFG  = 8;
    localparam int TMO  = 64;
    localparam int MAXR = 2;

    logic           osc_clk = 1'b0;
    logic           rstn, start, device_detect, por;
    logic [NCH-1:0] chan_en, fs_mac_rdy, tx_transfer_en, rx_transfer_en;
    logic [NCH-1:0] config_done, tx_req, rx_req;
    logic           link_up, link_fail;
    logic [3:0]     retry_cnt;
    logic [2:0]     state_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    aib_link_seq #(
        .NCH(NCH), .CFG_CYC(CFG), .TMO_CYC(TMO), .MAX_RETRY(MAXR)
    ) dut (
        .osc_clk             (osc_clk),
        .rstn                (rstn),
        .start               (start),
        .chan_en             (chan_en),
        .device_detect       (device_detect),
        .por                 (por),
        .fs_mac_rdy          (fs_mac_rdy),
        .tx_transfer_en      (tx_transfer_en),
        .rx_transfer_en      (rx_transfer_en),
        .config_done         (config_done),
        .tx_dcc_dll_lock_req (tx_req),
        .rx_dcc_dll_lock_req (rx_req),
        .link_up             (link_up),
        .link_fail           (link_fail),
        .retry_cnt           (retry_cnt),
        .state_o             (state_o)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    // Reference model: phase number, cycles spent in the phase, latched mask, retries used.
    int       m_st = 0;
    int       m_age = 0;
    int       m_rty = 0;
    bit [3:0] m_mask = '0;

    always @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            m_st = 0; m_age = 0; m_rty = 0; m_mask = '0;
        end else begin
            int nx;
            bit all_x, all_f;
            nx    = m_st;
            all_x = ((tx_transfer_en & rx_transfer_en & m_mask) == m_mask);
            all_f = ((fs_mac_rdy & m_mask) == m_mask);
            if (!start) begin
                nx = 0; m_rty = 0; m_mask = '0;
            end else begin
                case (m_st)
                    0: if (chan_en == 0) nx = 6; else begin m_mask = chan_en; nx = 1; end
                    1: if (device_detect && !por && all_f) nx = 2;
                       else if (m_age + 1 == TMO) nx = 6;
                    2: if (m_age + 1 == CFG) nx = 3;
                    3: if (all_x) nx = 4;
                       else if (m_age + 1 == TMO) begin nx = 5; m_rty++; end
                    4: if (!(all_x && all_f)) begin nx = 5; m_rty++; end
                    5: nx = (m_rty == MAXR) ? 6 : 2;
                    default: nx = m_st;
                endcase
            end
            m_age = (nx == m_st) ? m_age + 1 : 0;
            m_st  = nx;
        end
    end

    function automatic int exp_cfg();
        return (m_st == 2 || m_st == 3 || m_st == 4) ? int'(m_mask) : 0;
    endfunction

    function automatic int exp_req();
        return (m_st == 3 || m_st == 4) ? int'(m_mask) : 0;
    endfunction

    always @(posedge osc_clk) begin
        #2;
        if (cmp_en) begin
            chk("cmp_state", int'(state_o), m_st);
            chk("cmp_cfg", int'(config_done), exp_cfg());
            chk("cmp_txreq", int'(tx_req), exp_req());
            chk("cmp_rxreq", int'(rx_req), exp_req());
            chk("cmp_link_up", int'(link_up), (m_st == 4) ? 1 : 0);
            chk("cmp_link_fail", int'(link_fail), (m_st == 6) ? 1 : 0);
            chk("cmp_retry", int'(retry_cnt), m_rty);
        end
    end

    initial begin
        int n, k, w, rv, stn, side;
        rstn = 1'b1; start = 1'b0; chan_en = '0; device_detect = 1'b0; por = 1'b0;
        fs_mac_rdy = '0; tx_transfer_en = '0; rx_transfer_en = '0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_outs", int'({config_done, tx_req, rx_req, link_up, link_fail, retry_cnt}), 0);
        cmp_en = 1;
        cyc(2);
        rstn = 1'b1;
        cyc(1);

        // Clean bring-up on all four channels.
        chan_en = 4'hF; device_detect = 1'b1; fs_mac_rdy = 4'hF; start = 1'b1;
        n = 0; k = 0;
        while (tx_req == 0 && n < 200) begin
            cyc(1); n++;
            if (config_done == 4'hF && tx_req == 0) k++;
        end
        chk("s1_lock_seen", (n < 200) ? 1 : 0, 1);
        chk("s1_cfg_cycles", k, 8);
        chk("s1_lock_val", int'({tx_req, rx_req}), 8'hFF);
        cyc(20);
        tx_transfer_en = 4'hF; rx_transfer_en = 4'hF;
        k = 20;
        while (!link_up && k < 60) begin cyc(1); k++; end
        chk("s1_link_latency", k, 21);

        // Link loss on rx channel 2.
        rx_transfer_en[2] = 1'b0;
        cyc(1);
        chk("s2_retry_state", int'(state_o), 5);
        chk("s2_retry_cnt", int'(retry_cnt), 1);
        chk("s2_outs_drop", int'({config_done, tx_req, rx_req}), 0);
        rx_transfer_en[2] = 1'b1;
        cyc(1);
        chk("s2_reconfig", int'(state_o), 2);
        n = 0;
        while (!link_up && n < 30) begin cyc(1); n++; end
        chk("s2_link_again", int'(link_up), 1);

        // Partial mask: channels 1 and 3 idle, chan_en changed after latch.
        start = 1'b0;
        cyc(1);
        chk("s3_idle", int'(state_o), 0);
        chk("s3_idle_retry", int'(retry_cnt), 0);
        chan_en = 4'b0101; fs_mac_rdy = 4'b0101;
        tx_transfer_en = 4'b0101; rx_transfer_en = 4'b0101; start = 1'b1;
        cyc(1);
        chan_en = 4'hF;
        side = 0; n = 0;
        while (!link_up && n < 40) begin
            cyc(1); n++;
            side |= int'((config_done | tx_req | rx_req) & 4'b1010);
        end
        chk("s3_link_up", int'(link_up), 1);
        chk("s3_unmasked_zero", side, 0);
        chk("s3_masked_val", int'(config_done), 4'b0101);

        // Retry exhaustion: transfers never come up.
        start = 1'b0;
        cyc(1);
        chan_en = 4'hF; fs_mac_rdy = 4'hF; tx_transfer_en = '0; rx_transfer_en = '0;
        start = 1'b1;
        n = 0; k = 0; w = 0; stn = 0;
        while (state_o != 6 && n < 400) begin
            cyc(1); n++;
            if (state_o == 5) begin
                k++;
                if (stn != 5) w++;
                side |= int'({config_done, tx_req, rx_req});
            end
            stn = int'(state_o);
        end
        chk("s4_reached_fail", int'(state_o), 6);
        chk("s4_retry_visits", w, 2);
        chk("s4_retry_cycles", k, 2);
        chk("s4_retry_outs", side, 0);
        chk("s4_link_fail", int'(link_fail), 1);
        chk("s4_retry_cnt", int'(retry_cnt), 2);

        // Detect timeout, then abort.
        start = 1'b0;
        cyc(1);
        device_detect = 1'b0; start = 1'b1;
        n = 0; w = 0;
        while (state_o != 6 && n < 200) begin
            cyc(1); n++;
            if (state_o == 1) w++;
        end
        chk("s5_wait_cycles", w, 64);
        chk("s5_fail", int'(link_fail), 1);
        start = 1'b0;
        cyc(1);
        chk("s5_abort_state", int'(state_o), 0);
        chk("s5_abort_retry", int'(retry_cnt), 0);

        // Asynchronous reset while in LOCK_REQ.
        device_detect = 1'b1; start = 1'b1;
        n = 0;
        while (state_o != 3 && n < 40) begin cyc(1); n++; end
        chk("s6_in_lock", int'(state_o), 3);
        #2 rstn = 1'b0;
        #1;
        chk("s6_async_outs", int'({config_done, tx_req, rx_req, link_up, link_fail}), 0);
        chk("s6_async_state", int'(state_o), 0);
        cyc(1);
        rstn = 1'b1;

        // Random traffic, checked every cycle by the compare process.
        tx_transfer_en = 4'hF; rx_transfer_en = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            rv = $urandom_range(0, 99);
            start = (rv >= 2);
            rstn = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 9) == 0) chan_en = 4'($urandom);
            device_detect = ($urandom_range(0, 9) != 0);
            por = ($urandom_range(0, 29) == 0);
            fs_mac_rdy = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'hF;
            tx_transfer_en = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'hF;
            rx_transfer_en = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'hF;
        end
        rstn = 1'b1;
        cyc(2);
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aib_link_seq.md
AIB_LINK_SEQ -- requirements
Module: aib_link_seq

Interface
REQ-001 SHALL have parameter NCH, default 4: number of AIB channels sequenced, 1..24.
REQ-002 SHALL have parameter CFG_CYC, default 8: cycles config_done is held before lock requests are raised, >=1.
REQ-003 SHALL have parameter TMO_CYC, default 1024: per-state timeout in osc_clk cycles, >=2.
REQ-004 SHALL have parameter MAX_RETRY, default 3: retries allowed before FAIL, 1..15.
REQ-005 SHALL have ports, one per line as: osc_clk  in  1  sole clock, all logic rising-edge.
- rstn  in  1  asynchronous active-low reset
- start  in  1  level; sequencing enabled while high
- chan_en  in  NCH  channel participation mask
- device_detect  in  1  far side present
- por  in  1  power-on reset, active high
- fs_mac_rdy  in  NCH  per-channel far-side MAC ready
- tx_transfer_en  in  NCH  per-channel TX transfer enable from channel
- rx_transfer_en  in  NCH  per-channel RX transfer enable from channel
- config_done  out  NCH  per-channel config done
- tx_dcc_dll_lock_req  out  NCH  per-channel TX lock request
- rx_dcc_dll_lock_req  out  NCH  per-channel RX lock request
- link_up  out  1  all enabled channels transferring
- link_fail  out  1  sequence abandoned
- retry_cnt  out  4  retries consumed
- state_o  out  3  current state encoding

Function
REQ-006 SHALL implement states IDLE=0, WAIT_DET=1, CONFIG=2, LOCK_REQ=3, LINK_UP=4, RETRY=5, FAIL=6.
REQ-007 SHALL, when start is low in any state, enter IDLE on the next edge, clearing retry_cnt and the latched mask.
REQ-008 SHALL, in IDLE with start high, latch chan_en into mask and enter WAIT_DET; mask all-zero SHALL enter FAIL instead.
REQ-009 SHALL, in WAIT_DET, enter CONFIG when device_detect=1, por=0 and fs_mac_rdy is 1 on every mask bit.
REQ-010 SHALL, in CONFIG, drive config_done=mask and enter LOCK_REQ after exactly CFG_CYC cycles in CONFIG.
REQ-011 SHALL, in LOCK_REQ, drive config_done, tx_dcc_dll_lock_req and rx_dcc_dll_lock_req = mask; enter LINK_UP when tx_transfer_en and rx_transfer_en are 1 on every mask bit.
REQ-012 SHALL, in LINK_UP, hold LOCK_REQ outputs, assert link_up, and enter RETRY when any masked tx/rx_transfer_en or fs_mac_rdy drops.
REQ-013 SHALL run a timer cleared on each state entry; in WAIT_DET and LOCK_REQ, TMO_CYC cycles without the exit condition SHALL fire timeout.
REQ-014 SHALL, on timeout, enter FAIL from WAIT_DET and RETRY from LOCK_REQ.
REQ-015 SHALL give the exit condition priority over timeout in the same cycle.
REQ-016 SHALL, in RETRY, drive all per-channel outputs 0 for exactly one cycle and increment retry_cnt.
REQ-017 SHALL, from RETRY, enter FAIL if the incremented retry_cnt equals MAX_RETRY, else CONFIG.
REQ-018 SHALL, in FAIL, drive all per-channel outputs 0 and link_fail=1 until start drops.
REQ-019 SHALL ignore unmasked channel inputs and drive 0 on unmasked outputs in all states.
REQ-020 SHALL ignore chan_en changes after latch until IDLE.
REQ-021 SHALL register every output, with no combinational input-to-output path.
REQ-022 SHALL update outputs in the same cycle as state_o, so config_done rises on the first CONFIG cycle.

Reset
REQ-023 SHALL, with rstn low, force state IDLE, timer 0, retry_cnt 0, mask 0, and all outputs 0.
REQ-024 SHALL, on rstn assertion mid-sequence, clear all outputs immediately without waiting for osc_clk.

Structure
REQ-025 SHALL place state encodings and retry_cnt width in package aib_link_seq_pkg.
REQ-026 SHALL implement the timer as sub-module aib_link_tmr, with parameter TMO_CYC and ports clr, tick, expired.

Verification
REQ-027 SHALL cover clean bring-up: NCH=4, chan_en=4'hF, detect/mac_rdy high, transfer_en high 20 cycles after lock_req -> config_done=4'hF for 8 cycles before lock_req, link_up 21 cycles after lock_req rise.
REQ-028 SHALL cover masking: chan_en=4'b0101, channels 1/3 inputs held 0 -> link_up; outputs on bits 1 and 3 stay 0 throughout.
REQ-029 SHALL cover retry exhaustion: MAX_RETRY=2, transfer_en never rises, TMO_CYC=64 -> two RETRY visits with one-cycle output drop each, then FAIL with link_fail=1, retry_cnt=2.
REQ-030 SHALL cover link loss: in LINK_UP, drop rx_transfer_en[2] one cycle -> RETRY next edge, retry_cnt=1, re-enter CONFIG, link_up again after restore.
REQ-031 SHALL cover detect timeout and abort: device_detect held 0 -> FAIL after 64 cycles; start low -> IDLE next edge, retry_cnt=0.
REQ-032 SHALL cover async reset: rstn low in LOCK_REQ between clock edges -> all outputs 0 immediately, state_o=0.
